jstk_responder: RTL and testbench
=================================

JSTK_RESPONDER -- requirements
Module: jstk_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages used to synchronize SS, SCLK and MOSI (minimum 2).
REQ-002 The block SHALL have parameter LED_RESET, default 2'b00, meaning the value loaded into led on reset.
REQ-003 Port clk, input, 1 bit: system clock; one clock; all state on rising edge.
REQ-004 Port rst_n, input, 1 bit: reset; asynchronous and active-low.
REQ-005 Port ss, input, 1 bit: slave select, active low, asynchronous to clk.
REQ-006 Port sclk, input, 1 bit: serial clock, SPI mode 0, asynchronous to clk.
REQ-007 Port mosi, input, 1 bit: master-to-slave data.
REQ-008 Port miso, output, 1 bit: slave-to-master data.
REQ-009 Port pos_x, input, 10 bits: joystick X position to report.
REQ-010 Port pos_y, input, 10 bits: joystick Y position to report.
REQ-011 Port buttons, input, 3 bits: button states to report.
REQ-012 Port led, output, 2 bits: LED state commanded by the master.
REQ-013 Port cmd_byte, output, 8 bits: first byte received in the last completed frame.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse when a full 40-bit frame completes.
REQ-015 Port frame_abort, output, 1 bit: one-cycle pulse when ss deasserts mid-frame.

Function
REQ-016 ss, sclk and mosi SHALL each pass through a SYNC_STAGES flip-flop synchronizer, and an extra register SHALL provide edge detection.
REQ-017 Correct operation SHALL be guaranteed when each sclk high and low phase lasts at least SYNC_STAGES+2 clk cycles, and when ss-fall to first sclk-rise is at least SYNC_STAGES+3 clk cycles.
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 In IDLE on synchronized ss fall, the block SHALL latch the 40-bit transmit frame {pos_x[7:0], 6'b0, pos_x[9:8], pos_y[7:0], 6'b0, pos_y[9:8], 5'b0, buttons}.
- On the same ss fall: clear the bit counter, go to SHIFT.
- Inputs sampled only at this point; later changes are ignored until the next frame.
REQ-020 miso SHALL present frame bit 39 (MSB first) within one clk cycle of the ss-fall detection.
REQ-021 In SHIFT on each synchronized sclk rise, the block SHALL shift synchronized mosi into the receive shift register and increment the 6-bit bit counter.
REQ-022 In SHIFT on each synchronized sclk fall, the block SHALL advance miso to the next frame bit.
- No advance after bit 0 has been presented.
REQ-023 After the 8th sclk rise, the block SHALL capture the receive register into a pending-command register.
REQ-024 After the 40th sclk rise, the FSM SHALL go to DONE.
- Further sclk edges are ignored until ss rises.
REQ-025 In DONE on ss rise, the block SHALL do all of the following, then return to IDLE:
- Copy pending command to cmd_byte.
- Pulse frame_done for exactly one cycle.
- If pending command[7:2]==6'b100000, load led <= command[1:0]; otherwise leave led unchanged.
REQ-026 In SHIFT on ss rise (fewer than 40 bits), the block SHALL pulse frame_abort for one cycle and return to IDLE.
- cmd_byte and led unchanged.
REQ-027 When ss is deasserted (synchronized high), miso SHALL be driven 0.
REQ-028 If ss-fall and an sclk edge are detected in the same cycle, the block SHALL process ss-fall only.
REQ-029 If ss-rise and an sclk edge are detected in the same cycle, ss-rise SHALL take priority and the edge SHALL be discarded.

Reset
REQ-030 While rst_n is low, the block SHALL hold the following regardless of ss/sclk activity:
- FSM=IDLE; miso=0; led=LED_RESET; cmd_byte=8'h00.
- frame_done=0; frame_abort=0; all shift and synchronizer registers cleared (ss synchronizer cleared to 1).
REQ-031 Reset asserted mid-frame SHALL abandon the frame without any pulse.
- After release, the next ss fall SHALL start a clean frame.

Verification
REQ-032 Scenario: pos_x=10'h2A5, pos_y=10'h13C, buttons=3'b101, master sends 8'h83 then 4 bytes 8'h00 -> master receives A5 02 3C 01 05; led=2'b11; cmd_byte=8'h83; one frame_done pulse.
REQ-033 Scenario: command 8'h40 in a full frame -> cmd_byte=8'h40; led unchanged; frame_done pulses.
REQ-034 Scenario: ss released after 17 bits -> frame_abort single pulse; no frame_done; led and cmd_byte unchanged; next full frame correct.
REQ-035 Scenario: pos_x changed 1 cycle after the ss-fall detection -> frame carries the old pos_x; the next frame carries the new value.
REQ-036 Scenario: rst_n pulsed low at bit 20 of a frame carrying 8'h82 -> led=LED_RESET; no pulses; subsequent full frame with 8'h81 gives led=2'b01.
REQ-037 Scenario: sclk half-period at the REQ-017 minimum for the full 40 bits -> every miso bit stable at each sclk rise; all bits received correctly.

Source files
------------

// File: rtl/jstk_responder.sv
`timescale 1ns / 1ps
// jstk_responder: SPI mode-0 slave that reports joystick position and buttons
// in a 40-bit frame and accepts a command byte from the master. The first
// received byte becomes cmd_byte when the frame completes. A command of the
// form 6'b100000_xx sets the LEDs to xx.
//
// ss, sclk and mosi are asynchronous to clk. Each is resynchronized, and sclk
// and ss are edge-detected in the clk domain. mosi passes through the same
// number of stages as sclk. The synchronized mosi therefore belongs to the
// same sample instant as the synchronized sclk edge.
//
// SYNC_STAGES must be at least 2.
//
// Handshake: this block has no valid/ready pair. frame_done and frame_abort
// are single-cycle strobes that are registered and never back-pressured.
// cmd_byte and led change only in the cycle that frame_done is high.
module jstk_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] LED_RESET   = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic [7:0] cmd_byte,
    output logic       frame_done,
    output logic       frame_abort,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [39:0]            tx_frame;
    logic [38:0]            tx_sr;
    logic [6:0]             rx_sr;
    logic [7:0]             rx_next;
    logic [7:0]             pend_cmd;
    logic [5:0]             bit_cnt;

    // Synchronizer chains plus one extra register each for ss/sclk edge
    // detection. ss idles high, so its chain resets to all ones. This avoids
    // a false ss fall when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_d      <= ss_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // Transmit frame: five bytes, MSB first.
    // Bytes are X low, X high, Y low, Y high, then buttons.
    assign tx_frame = {pos_x[7:0], 6'b0, pos_x[9:8],
                       pos_y[7:0], 6'b0, pos_y[9:8],
                       5'b0, buttons};
    assign rx_next  = {rx_sr, mosi_s};
    assign state_dbg = state;

    // Frame FSM. ss edges always win over sclk edges in the same cycle.
    // miso holds the bit currently presented to the master. tx_sr holds the
    // bits still to be presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            miso        <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            pend_cmd    <= '0;
            bit_cnt     <= '0;
            led         <= LED_RESET;
            cmd_byte    <= 8'h00;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (ss_fall) begin
                        miso    <= tx_frame[39];
                        tx_sr   <= tx_frame[38:0];
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sr   <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            pend_cmd <= rx_next;
                        end
                        if (bit_cnt == 6'd39) begin
                            state <= DONE;
                        end
                    end else if (sclk_fall && bit_cnt != 6'd0) begin
                        // A fall before the first rise would skip bit 39.
                        miso  <= tx_sr[38];
                        tx_sr <= {tx_sr[37:0], 1'b0};
                    end
                end
                DONE: begin
                    if (ss_rise) begin
                        cmd_byte   <= pend_cmd;
                        frame_done <= 1'b1;
                        if (pend_cmd[7:2] == 6'b100000) begin
                            led <= pend_cmd[1:0];
                        end
                        miso  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_responder.sv
`timescale 1ns / 1ps
// Bench for jstk_responder: acts as an SPI mode-0 master on the tb clock.
// Expected miso bytes are queued per frame and popped as bytes are received.
module tb_jstk_responder;

    localparam int         SYNC_STAGES = 2;
    localparam logic [1:0] LED_RESET   = 2'b00;
    localparam int         HP          = 6;
    localparam int         MIN_HP      = SYNC_STAGES + 2;

    logic       clk;
    logic       rst_n;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [2:0] buttons;
    logic [1:0] led;
    logic [7:0] cmd_byte;
    logic       frame_done;
    logic       frame_abort;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    int         n_vec;
    int         n_err;
    int         done_cnt;
    int         abort_cnt;
    logic [1:0] exp_led;
    logic [7:0] exp_cmd;

    jstk_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .LED_RESET  (LED_RESET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .buttons    (buttons),
        .led        (led),
        .cmd_byte   (cmd_byte),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .state_dbg  (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes away from the active edge.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    // Scoreboard push: the five bytes the slave should return.
    task automatic push_frame_exp(input logic [9:0] px, input logic [9:0] py,
                                  input logic [2:0] b);
        exp_q.push_back(px[7:0]);
        exp_q.push_back({6'b0, px[9:8]});
        exp_q.push_back(py[7:0]);
        exp_q.push_back({6'b0, py[9:8]});
        exp_q.push_back({5'b0, b});
    endtask

    // Driver: one SPI frame of nbits bits. miso is captured at each sclk rise.
    // With rst_mid set, reset is pulsed after nbits bits and ss is released
    // while reset is held.
    task automatic spi_xfer(input logic [39:0] tx, input int nbits, input int half,
                            input bit rst_mid, output logic [39:0] rx);
        rx = '0;
        @(negedge clk);
        mosi = tx[39];
        ss   = 1'b0;
        repeat (SYNC_STAGES + 4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk      = 1'b1;
            rx[39-i]  = miso;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if (i < 39) mosi = tx[38-i];
            repeat (half) @(negedge clk);
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            ss = 1'b1;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            ss = 1'b1;
        end
        repeat (SYNC_STAGES + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", miso); end
        n_vec++; if (led !== LED_RESET) begin n_err++; $display("FAIL reset_led got %b want %b", led, LED_RESET); end
        n_vec++; if (cmd_byte !== 8'h00) begin n_err++; $display("FAIL reset_cmd got %h want 00", cmd_byte); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", frame_done); end
        n_vec++; if (frame_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort got %b want 0", frame_abort); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    endtask

    task automatic test_full_frame();
        logic [39:0] rx;
        logic [7:0]  e;
        int d0, a0;
        pos_x = 10'h2A5; pos_y = 10'h13C; buttons = 3'b101;
        d0 = done_cnt; a0 = abort_cnt;
        push_frame_exp(pos_x, pos_y, buttons);
        spi_xfer({8'h83, 32'h0}, 40, HP, 1'b0, rx);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL full_byte%0d got %h want %h", k, rx[39-8*k -: 8], e); end
        end
        exp_led = 2'b11; exp_cmd = 8'h83;
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL full_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL full_cmd got %h want %h", cmd_byte, exp_cmd); end
        n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL full_done_pulses got %0d want 1", done_cnt - d0); end
        n_vec++; if (abort_cnt - a0 !== 0) begin n_err++; $display("FAIL full_abort_pulses got %0d want 0", abort_cnt - a0); end
        n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL full_idle_miso got %b want 0", miso); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL full_idle_state got %0d want 0", state_dbg); end
    endtask

    task automatic test_cmd_no_led();
        logic [39:0] rx;
        int d0;
        d0 = done_cnt;
        spi_xfer({8'h40, 32'hFFFF_FFFF}, 40, HP, 1'b0, rx);
        exp_cmd = 8'h40;
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL nocmd_cmd got %h want %h", cmd_byte, exp_cmd); end
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL nocmd_led got %b want %b", led, exp_led); end
        n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL nocmd_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        logic [39:0] rx;
        logic [7:0]  e;
        int d0, a0;
        d0 = done_cnt; a0 = abort_cnt;
        spi_xfer({8'h82, 32'h0}, 17, HP, 1'b0, rx);
        n_vec++; if (abort_cnt - a0 !== 1) begin n_err++; $display("FAIL abort_pulses got %0d want 1", abort_cnt - a0); end
        n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL abort_done_pulses got %0d want 0", done_cnt - d0); end
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL abort_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL abort_cmd got %h want %h", cmd_byte, exp_cmd); end
        pos_x = 10'h3C7; pos_y = 10'h0F1; buttons = 3'b010;
        push_frame_exp(pos_x, pos_y, buttons);
        spi_xfer({8'h81, 32'h0}, 40, HP, 1'b0, rx);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL after_abort_byte%0d got %h want %h", k, rx[39-8*k -: 8], e); end
        end
        exp_led = 2'b01; exp_cmd = 8'h81;
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL after_abort_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL after_abort_cmd got %h want %h", cmd_byte, exp_cmd); end
    endtask

    task automatic test_sample_point();
        logic [39:0] rx;
        logic [7:0]  e;
        pos_x = 10'h155; pos_y = 10'h2AA; buttons = 3'b111;
        push_frame_exp(10'h155, pos_y, buttons);
        fork
            spi_xfer({8'h00, 32'h0}, 40, HP, 1'b0, rx);
            begin
                wait (ss == 1'b0);
                repeat (3) @(negedge clk);
                pos_x = 10'h0AA;
            end
        join
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL old_x_byte%0d got %h want %h", k, rx[39-8*k -: 8], e); end
        end
        exp_cmd = 8'h00;
        push_frame_exp(10'h0AA, pos_y, buttons);
        spi_xfer({8'h00, 32'h0}, 40, HP, 1'b0, rx);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL new_x_byte%0d got %h want %h", k, rx[39-8*k -: 8], e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] rx;
        int d0, a0;
        d0 = done_cnt; a0 = abort_cnt;
        spi_xfer({8'h82, 32'h0}, 20, HP, 1'b1, rx);
        exp_led = LED_RESET; exp_cmd = 8'h00;
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL rstmid_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL rstmid_cmd got %h want %h", cmd_byte, exp_cmd); end
        n_vec++; if ((done_cnt - d0) + (abort_cnt - a0) !== 0) begin n_err++; $display("FAIL rstmid_pulses got %0d want 0", (done_cnt - d0) + (abort_cnt - a0)); end
        spi_xfer({8'h81, 32'h0}, 40, HP, 1'b0, rx);
        exp_led = 2'b01; exp_cmd = 8'h81;
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL rstmid_next_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL rstmid_next_cmd got %h want %h", cmd_byte, exp_cmd); end
    endtask

    task automatic test_min_timing();
        logic [39:0] rx;
        logic [7:0]  e;
        pos_x = 10'($urandom_range(0, 1023)); pos_y = 10'($urandom_range(0, 1023));
        buttons = 3'($urandom_range(0, 7));
        push_frame_exp(pos_x, pos_y, buttons);
        spi_xfer({8'h82, 32'h0}, 40, MIN_HP, 1'b0, rx);
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL min_byte%0d got %h want %h", k, rx[39-8*k -: 8], e); end
        end
        exp_led = 2'b10; exp_cmd = 8'h82;
        n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL min_led got %b want %b", led, exp_led); end
        n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL min_cmd got %h want %h", cmd_byte, exp_cmd); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] rx;
        logic [7:0]  e;
        logic [7:0]  c;
        for (int f = 0; f < 6; f++) begin
            pos_x = 10'($urandom_range(0, 1023)); pos_y = 10'($urandom_range(0, 1023));
            buttons = 3'($urandom_range(0, 7));
            c = (f % 2 == 0) ? {6'b100000, 2'($urandom_range(0, 3))} : 8'($urandom_range(0, 255));
            push_frame_exp(pos_x, pos_y, buttons);
            spi_xfer({c, 32'($urandom)}, 40, (f % 2 == 0) ? MIN_HP : HP, 1'b0, rx);
            for (int k = 0; k < 5; k++) begin
                e = exp_q.pop_front();
                n_vec++;
                if (rx[39-8*k -: 8] !== e) begin n_err++; $display("FAIL b2b%0d_byte%0d got %h want %h", f, k, rx[39-8*k -: 8], e); end
            end
            exp_cmd = c;
            if (c[7:2] == 6'b100000) exp_led = c[1:0];
            n_vec++; if (cmd_byte !== exp_cmd) begin n_err++; $display("FAIL b2b%0d_cmd got %h want %h", f, cmd_byte, exp_cmd); end
            n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL b2b%0d_led got %b want %b", f, led, exp_led); end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; done_cnt = 0; abort_cnt = 0;
        exp_led = LED_RESET; exp_cmd = 8'h00;
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        pos_x = '0; pos_y = '0; buttons = '0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_full_frame();
        test_cmd_no_led();
        test_abort();
        test_sample_point();
        test_reset_mid_frame();
        test_min_timing();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
